pong_axil_arbiter: RTL
======================

PONG_AXIL_ARBITER -- requirements
Module: pong_axil_arbiter

Interface
REQ-001 C_S_AXI_DATA_WIDTH, default 32, data width of the pong register bus; only 32 is supported.
REQ-002 C_S_AXI_ADDR_WIDTH, default 4, byte address width covering 4 registers.
REQ-003 ACLK  in  1  clock; all state SHALL update on the rising edge.
REQ-004 ARESET  in  1  synchronous active-high reset.
REQ-005 rq_valid  in  2  per-requester request valid; the requester SHALL hold it with its payload stable until rq_ready.
REQ-006 rq_ready  out  2  one-cycle grant/accept pulse per requester.
REQ-007 rq_we  in  2  1 = write, 0 = read, per requester.
REQ-008 rq_idx  in  4  register index, 2 bits per requester ([1:0] = req0).
REQ-009 rq_wdata  in  64  write data, 32 bits per requester.
REQ-010 rs_valid  out  2  one-cycle completion pulse to the granted requester; no backpressure.
REQ-011 rs_rdata / rs_resp  out  32 / 2  read data (0 for writes) and AXI response, valid with rs_valid.
REQ-012 txn_cnt / err_cnt  out  16 / 8  completed transactions (wraps) and non-OKAY responses (saturates at 255).
REQ-013 m_axi_awaddr out 4, awprot out 3, awvalid out 1, awready in 1: AW channel.
REQ-014 m_axi_wdata out 32, wstrb out 4, wvalid out 1, wready in 1: W channel.
REQ-015 m_axi_bresp in 2, bvalid in 1, bready out 1: B channel.
REQ-016 m_axi_araddr out 4, arprot out 3, arvalid out 1, arready in 1: AR channel.
REQ-017 m_axi_rdata in 32, rresp in 2, rvalid in 1, rready out 1: R channel.

Function
REQ-018 FSM states SHALL be IDLE, WRITE, BWAIT, READ, RWAIT, RESP.
REQ-019 Arbitration occurs only in IDLE: single valid wins; on a tie the requester other than last_grant wins; rq_ready[g] asserts combinationally that cycle and the payload is captured.
REQ-020 IDLE with a captured write -> WRITE; with a captured read -> READ; no rq_ready while not IDLE.
REQ-021 WRITE: awvalid and wvalid assert together, awaddr = {idx,2'b00}, wstrb = 4'hF, awprot = 0; each valid drops independently after its own handshake; -> BWAIT once both have completed (same cycle allowed).
REQ-022 BWAIT: bready = 1; on bvalid capture bresp -> RESP.
REQ-023 READ: arvalid held with araddr = {idx,2'b00}, arprot = 0 until arready -> RWAIT.
REQ-024 RWAIT: rready = 1; on rvalid capture rdata, rresp -> RESP.
REQ-025 RESP: rs_valid[g] = 1 for exactly one cycle; txn_cnt += 1; err_cnt += 1 if resp != 2'b00 (saturating); last_grant <= g; -> IDLE.
REQ-026 Latency with a zero-wait slave SHALL be 3 cycles from the rq_ready cycle to the rs_valid cycle; the next grant occurs no earlier than the cycle after RESP.
REQ-027 Valids SHALL never drop before their handshake, and addresses/data SHALL stay stable while valid (AXI4-Lite rules).
REQ-028 Slave responses arriving in states other than BWAIT/RWAIT SHALL be ignored (bready/rready low).

Reset
REQ-029 On ARESET all AXI valid/ready outputs, rq_ready, rs_valid, rs_rdata, rs_resp, txn_cnt and err_cnt SHALL be 0, state = IDLE, last_grant = 1 (req0 wins the first tie).
REQ-030 ARESET mid-transaction SHALL abandon the transaction without a rs_valid pulse; ARESET SHALL be shared with the pong slave.
REQ-031 The first grant SHALL be possible in the first cycle after ARESET deasserts.

Structure
REQ-032 A shared package pong_axil_pkg SHALL hold the state enum, AXI response constants (OKAY/SLVERR/DECERR) and the register index typedef.
REQ-033 No sub-module is required; the arbiter is a single FSM plus capture registers and counters.

Verification
REQ-034 req0 writes idx0 = 0x00000001 then reads idx0 -> AW addr 0x0, W 0x00000001 with wstrb F, rs_resp 0, read returns 0x00000001, txn_cnt = 2.
REQ-035 After reset, req0 (write idx1 0xA5) and req1 (write idx2 0x5A) assert in the same cycle -> req0 granted first, req1 second; a repeated tie grants req0.
REQ-036 awready delayed 3 cycles with wready immediate -> wvalid high for 1 cycle, awvalid held 4 cycles, exactly one B handshake, one rs_valid pulse.
REQ-037 Slave returns bresp = 2'b10 -> rs_resp = 2'b10, err_cnt 0 -> 1, txn_cnt increments.
REQ-038 ARESET pulsed during RWAIT -> next cycle all outputs at reset values, no rs_valid; a subsequent read of idx3 completes normally.
REQ-039 Writes idx0..3 = 1..4 then reads idx0..3 -> data 1..4 returned, txn_cnt = 8, err_cnt = 0.

Source files
------------

// File: rtl/pong_axil_pkg.sv
// Shared types and constants for the pong AXI4-Lite register bus.
package pong_axil_pkg;

    // Arbiter FSM states
    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StBwait,
        StRead,
        StRwait,
        StResp
    } state_e;

    // AXI response codes
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;
    localparam logic [1:0] RespDecerr = 2'b11;

    // Index of one of the four 32-bit pong registers
    typedef logic [1:0] reg_idx_t;

endpackage

// File: rtl/pong_axil_arbiter.sv
// Two-requester arbiter that turns simple request/response transactions into
// single AXI4-Lite accesses on the pong register bus.
module pong_axil_arbiter
    import pong_axil_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    // requester side
    input  logic [1:0]                        rq_valid,
    output logic [1:0]                        rq_ready,
    input  logic [1:0]                        rq_we,
    input  logic [3:0]                        rq_idx,
    input  logic [2*C_S_AXI_DATA_WIDTH-1:0]   rq_wdata,
    output logic [1:0]                        rs_valid,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     rs_rdata,
    output logic [1:0]                        rs_resp,
    output logic [15:0]                       txn_cnt,
    output logic [7:0]                        err_cnt,
    // AXI4-Lite manager
    output logic [C_S_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [2:0]                        m_axi_awprot,
    output logic                              m_axi_awvalid,
    input  logic                              m_axi_awready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                              m_axi_wvalid,
    input  logic                              m_axi_wready,
    input  logic [1:0]                        m_axi_bresp,
    input  logic                              m_axi_bvalid,
    output logic                              m_axi_bready,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [2:0]                        m_axi_arprot,
    output logic                              m_axi_arvalid,
    input  logic                              m_axi_arready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                        m_axi_rresp,
    input  logic                              m_axi_rvalid,
    output logic                              m_axi_rready
);

    state_e                         state_q, state_d;
    logic                           grant_q, grant_d;
    logic                           last_grant_q, last_grant_d;
    reg_idx_t                       idx_q, idx_d;
    logic [C_S_AXI_DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic                           aw_done_q, aw_done_d;
    logic                           w_done_q, w_done_d;
    logic [C_S_AXI_DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic [1:0]                     resp_q, resp_d;
    logic [15:0]                    txn_cnt_q, txn_cnt_d;
    logic [7:0]                     err_cnt_q, err_cnt_d;
    logic                           sel;

    // State, capture registers and counters; synchronous reset abandons any transaction
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q      <= StIdle;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            idx_q        <= '0;
            wdata_q      <= '0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            rdata_q      <= '0;
            resp_q       <= RespOkay;
            txn_cnt_q    <= '0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            rdata_q      <= rdata_d;
            resp_q       <= resp_d;
            txn_cnt_q    <= txn_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    // Next-state logic, arbitration and AXI handshake outputs
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        idx_d         = idx_q;
        wdata_d       = wdata_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        rdata_d       = rdata_q;
        resp_d        = resp_q;
        txn_cnt_d     = txn_cnt_q;
        err_cnt_d     = err_cnt_q;
        sel           = 1'b0;
        rq_ready      = '0;
        rs_valid      = '0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (|rq_valid) begin
                    // On a tie the requester that did not win last time goes first
                    sel           = (&rq_valid) ? ~last_grant_q : rq_valid[1];
                    rq_ready[sel] = 1'b1;
                    grant_d       = sel;
                    idx_d         = sel ? rq_idx[3:2] : rq_idx[1:0];
                    wdata_d       = sel ? rq_wdata[2*C_S_AXI_DATA_WIDTH-1:C_S_AXI_DATA_WIDTH]
                                        : rq_wdata[C_S_AXI_DATA_WIDTH-1:0];
                    aw_done_d     = 1'b0;
                    w_done_d      = 1'b0;
                    state_d       = rq_we[sel] ? StWrite : StRead;
                end
            end
            StWrite: begin
                m_axi_awvalid = ~aw_done_q;
                m_axi_wvalid  = ~w_done_q;
                aw_done_d     = aw_done_q | m_axi_awready;
                w_done_d      = w_done_q | m_axi_wready;
                if (aw_done_d && w_done_d) begin
                    state_d = StBwait;
                end
            end
            StBwait: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    resp_d  = m_axi_bresp;
                    rdata_d = '0;
                    state_d = StResp;
                end
            end
            StRead: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) begin
                    state_d = StRwait;
                end
            end
            StRwait: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid) begin
                    rdata_d = m_axi_rdata;
                    resp_d  = m_axi_rresp;
                    state_d = StResp;
                end
            end
            StResp: begin
                rs_valid[grant_q] = 1'b1;
                txn_cnt_d         = txn_cnt_q + 16'd1;
                if (resp_q != RespOkay && err_cnt_q != 8'hFF) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
                last_grant_d = grant_q;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Handshake outputs stay quiet while reset is held
        if (ARESET) begin
            rq_ready      = '0;
            rs_valid      = '0;
            m_axi_awvalid = 1'b0;
            m_axi_wvalid  = 1'b0;
            m_axi_bready  = 1'b0;
            m_axi_arvalid = 1'b0;
            m_axi_rready  = 1'b0;
        end
    end

    assign m_axi_awaddr = C_S_AXI_ADDR_WIDTH'({idx_q, 2'b00});
    assign m_axi_araddr = C_S_AXI_ADDR_WIDTH'({idx_q, 2'b00});
    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;
    assign m_axi_wdata  = wdata_q;
    assign m_axi_wstrb  = '1;
    assign rs_rdata     = rdata_q;
    assign rs_resp      = resp_q;
    assign txn_cnt      = txn_cnt_q;
    assign err_cnt      = err_cnt_q;

endmodule
